// File: rtl/ddmtd_beat_pd.sv
// Purpose : DDMTD beat phase detector; measures fb-minus-ref beat edge delay and ref beat period in helper ticks.
// Latency : phase_err/phase_valid appear one clk after the measuring tick; period/miss update on the tick itself.
// Backpress: none; ena=0 freezes all state and masks phase_valid, helper_tick gates every state change.
module ddmtd_beat_pd #(
   parameter int COUNT_W    = 16,
   parameter int BLANK      = 8,
   parameter int MIN_PERIOD = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      helper_tick,
   input  logic                      ref_beat,
   input  logic                      fb_beat,
   output logic                      phase_valid,
   output logic signed [COUNT_W-1:0] phase_err,
   output logic        [COUNT_W-1:0] beat_period,
   output logic                      period_valid,
   output logic                      miss
);

   // Blank counter must hold the value BLANK; the +2 keeps the width non-zero when BLANK is 0.
   localparam int                   BLANK_W  = $clog2(BLANK + 2);
   localparam logic [BLANK_W-1:0]   BLANK_LD = BLANK_W'(BLANK);
   localparam logic [COUNT_W-1:0]   MIN_P    = COUNT_W'(MIN_PERIOD);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_REF,
      WAIT_FB
   } state_t;

   state_t                     state_q, state_d;
   logic        [COUNT_W-1:0]  tick_cnt;
   logic        [COUNT_W-1:0]  ref_stamp;
   logic                       have_ref;
   logic                       ref_prev, fb_prev;
   logic        [BLANK_W-1:0]  ref_blank, fb_blank;
   logic                       pv_q;

   logic                       tick;
   logic                       ref_edge, fb_edge;
   logic        [COUNT_W-1:0]  since_ref;
   logic        [COUNT_W-1:0]  half_period;
   logic signed [COUNT_W-1:0]  wrapped;
   logic                       period_ok;
   logic                       period_drop;
   logic                       meas_fire;
   logic                       meas_zero;
   logic                       set_miss;

   // Edge qualification and shared arithmetic; since_ref doubles as the period and the raw delay.
   always_comb begin
      tick        = ena & helper_tick;
      ref_edge    = tick & ref_beat & ~ref_prev & (ref_blank == '0);
      fb_edge     = tick & fb_beat  & ~fb_prev  & (fb_blank  == '0);
      since_ref   = tick_cnt - ref_stamp;
      half_period = beat_period >> 1;
      wrapped     = (since_ref <= half_period) ? $signed(since_ref)
                                               : $signed(since_ref - beat_period);
      period_ok   = (since_ref >= MIN_P);
      // A too-short period invalidates tracking and aborts any open measurement this tick.
      period_drop = ref_edge & have_ref & ~period_ok;
   end

   // Measurement FSM: next state plus the measurement/miss strobes for this tick.
   always_comb begin
      state_d   = state_q;
      meas_fire = 1'b0;
      meas_zero = 1'b0;
      set_miss  = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (period_valid && !period_drop) state_d = WAIT_REF;
            end
            WAIT_REF: begin
               if (period_drop) begin
                  state_d = IDLE;
               end else if (ref_edge && fb_edge) begin
                  meas_zero = 1'b1;
               end else if (ref_edge) begin
                  state_d = WAIT_FB;
               end
            end
            WAIT_FB: begin
               if (period_drop) begin
                  state_d = IDLE;
               end else if (fb_edge) begin
                  // A coincident ref edge closes this measurement and opens the next one.
                  meas_fire = 1'b1;
                  state_d   = ref_edge ? WAIT_FB : WAIT_REF;
               end else if (ref_edge) begin
                  set_miss = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Tick counter, beat history and per-channel blanking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt  <= '0;
         ref_prev  <= 1'b0;
         fb_prev   <= 1'b0;
         ref_blank <= '0;
         fb_blank  <= '0;
      end else if (tick) begin
         tick_cnt <= tick_cnt + 1'b1;
         ref_prev <= ref_beat;
         fb_prev  <= fb_beat;
         if (ref_edge)             ref_blank <= BLANK_LD;
         else if (ref_blank != '0) ref_blank <= ref_blank - 1'b1;
         if (fb_edge)              fb_blank  <= BLANK_LD;
         else if (fb_blank != '0)  fb_blank  <= fb_blank - 1'b1;
      end
   end

   // Ref timestamping, period measurement and the sticky miss flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_stamp    <= '0;
         have_ref     <= 1'b0;
         beat_period  <= '0;
         period_valid <= 1'b0;
         miss         <= 1'b0;
      end else if (tick) begin
         if (ref_edge) begin
            ref_stamp <= tick_cnt;
            have_ref  <= 1'b1;
            if (have_ref) begin
               if (period_ok) begin
                  beat_period  <= since_ref;
                  period_valid <= 1'b1;
               end else begin
                  period_valid <= 1'b0;
               end
            end
         end
         if (set_miss) miss <= 1'b1;
      end
   end

   // Phase result register; the strobe lives for exactly one clk after the measuring tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pv_q      <= 1'b0;
         phase_err <= '0;
      end else begin
         pv_q <= meas_fire | meas_zero;
         if (meas_fire)      phase_err <= wrapped;
         else if (meas_zero) phase_err <= '0;
      end
   end

   // The strobe is suppressed on any clk where the block is disabled.
   always_comb begin
      phase_valid = pv_q & ena;
   end

endmodule

// File: tb/tb_ddmtd_beat_pd.sv
module tb_ddmtd_beat_pd;

   localparam int W    = 16;
   localparam int BLK  = 8;
   localparam int MINP = 16;
   localparam int MASK = (1 << W) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                ena = 1'b0;
   logic                helper_tick = 1'b0;
   logic                ref_beat = 1'b0;
   logic                fb_beat = 1'b0;
   logic                phase_valid;
   logic signed [W-1:0] phase_err;
   logic        [W-1:0] beat_period;
   logic                period_valid;
   logic                miss;

   ddmtd_beat_pd #(.COUNT_W(W), .BLANK(BLK), .MIN_PERIOD(MINP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .helper_tick  (helper_tick),
      .ref_beat     (ref_beat),
      .fb_beat      (fb_beat),
      .phase_valid  (phase_valid),
      .phase_err    (phase_err),
      .beat_period  (beat_period),
      .period_valid (period_valid),
      .miss         (miss)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Stimulus waveform state: bt is beat time in helper ticks.
   int cyc = 0;
   int bt  = 0;
   int P   = 100;
   int OFF = 10;
   bit fb_hold = 1'b0;
   bit glitch  = 1'b0;
   int pv_run = 0;
   int pv_run_max = 0;

   // Pulses as {cycle, phase}: expected from the model, observed from the DUT.
   logic [47:0] exp_q[$];
   logic [47:0] dut_q[$];

   // Reference model: times are absolute tick indices; -1 means "none".
   int          m_tick;
   bit          m_rp, m_fp;
   int          m_rblk, m_fblk;
   int          m_last_ref;
   int          m_period;
   bit          m_pv, m_miss, m_armed;
   int          m_open;
   logic [15:0] m_perr;

   function automatic bit ref_lvl(int t);
      return (t % P) < (P / 2);
   endfunction

   function automatic bit fb_lvl(int t);
      int d;
      d = (((t - OFF) % P) + P) % P;
      return d < (P / 2);
   endfunction

   task automatic model_step(input bit r, input bit e, input bit h,
                             input bit rb, input bit fb, output bit pulse);
      int t, p, raw, old_period;
      bit re, fe, old_pv, drop;
      pulse = 1'b0;
      if (!r) begin
         m_tick = 0; m_rp = 0; m_fp = 0; m_rblk = -1; m_fblk = -1;
         m_last_ref = -1; m_period = 0; m_pv = 0; m_miss = 0;
         m_armed = 0; m_open = -1; m_perr = '0;
         return;
      end
      if (!(e && h)) return;
      t  = m_tick;
      // An accepted edge blocks its channel for the following BLK ticks.
      re = rb && !m_rp && (t > m_rblk);
      fe = fb && !m_fp && (t > m_fblk);
      old_period = m_period;
      old_pv = m_pv;
      drop = 1'b0;
      if (re && m_last_ref >= 0) begin
         p = (t - m_last_ref) & MASK;
         if (p >= MINP) begin m_period = p; m_pv = 1'b1; end
         else begin m_pv = 1'b0; drop = 1'b1; end
      end
      if (!m_armed) begin
         if (old_pv && !drop) begin m_armed = 1'b1; m_open = -1; end
      end else if (drop) begin
         m_armed = 1'b0; m_open = -1;
      end else if (m_open < 0) begin
         if (re && fe) begin pulse = 1'b1; m_perr = '0; end
         else if (re) m_open = t;
      end else begin
         if (fe) begin
            raw = (t - m_open) & MASK;
            m_perr = (raw <= old_period / 2) ? 16'(raw) : 16'(raw - old_period);
            pulse = 1'b1;
            m_open = re ? t : -1;
         end else if (re) begin
            m_miss = 1'b1;
            m_open = t;
         end
      end
      if (re) begin m_last_ref = t; m_rblk = t + BLK; end
      if (fe) m_fblk = t + BLK;
      m_rp = rb;
      m_fp = fb;
      m_tick++;
   endtask

   // One clk: drive inputs, advance the model, sample the DUT 1 time unit after the edge.
   task automatic step(input bit r, input bit e, input bit h);
      bit rb, fb, pulse;
      rb = ref_lvl(bt);
      if (glitch && (bt % P) == 1) rb = 1'b0;
      fb = fb_hold ? 1'b0 : fb_lvl(bt);
      rst_n = r; ena = e; helper_tick = h; ref_beat = rb; fb_beat = fb;
      @(posedge clk);
      model_step(r, e, h, rb, fb, pulse);
      if (r && e && h) bt++;
      #1;
      if (pulse) exp_q.push_back({cyc, m_perr});
      if (phase_valid === 1'b1) begin
         dut_q.push_back({cyc, phase_err});
         pv_run++;
         if (pv_run > pv_run_max) pv_run_max = pv_run;
      end else begin
         pv_run = 0;
      end
      cyc++;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
   endtask

   task automatic clear_obs();
      exp_q.delete();
      dut_q.delete();
      pv_run = 0;
      pv_run_max = 0;
   endtask

   task automatic do_reset();
      glitch = 1'b0;
      fb_hold = 1'b0;
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      bt = 0;
      clear_obs();
   endtask

   task automatic test_reset();
      P = 100; OFF = 10;
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      tests++; if (phase_valid !== 1'b0) begin fails++; $display("FAIL reset_phase_valid: got %b want 0", phase_valid); end
      tests++; if (phase_err !== 16'sd0) begin fails++; $display("FAIL reset_phase_err: got %0d want 0", phase_err); end
      tests++; if (beat_period !== 16'd0) begin fails++; $display("FAIL reset_beat_period: got %0d want 0", beat_period); end
      tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL reset_period_valid: got %b want 0", period_valid); end
      tests++; if (miss !== 1'b0) begin fails++; $display("FAIL reset_miss: got %b want 0", miss); end
      tests++; if (dut.tick_cnt !== 16'd0) begin fails++; $display("FAIL reset_tick_cnt: got %0d want 0", dut.tick_cnt); end
      bt = 0;
      clear_obs();
   endtask

   task automatic test_lock_plus10();
      do_reset();
      P = 100; OFF = 10;
      run_ticks(650);
      tests++; if (beat_period !== 16'd100) begin fails++; $display("FAIL plus10_period: got %0d want 100", beat_period); end
      tests++; if (period_valid !== 1'b1) begin fails++; $display("FAIL plus10_period_valid: got %b want 1", period_valid); end
      tests++; if (miss !== 1'b0) begin fails++; $display("FAIL plus10_miss: got %b want 0", miss); end
      tests++; if (dut_q.size() != 5) begin fails++; $display("FAIL plus10_pulse_count: got %0d want 5", dut_q.size()); end
      tests++; if (pv_run_max != 1) begin fails++; $display("FAIL plus10_pulse_width: got %0d clks want 1", pv_run_max); end
      foreach (dut_q[i]) begin
         tests++;
         if (dut_q[i][15:0] !== 16'sd10) begin fails++; $display("FAIL plus10_phase[%0d]: got %0d want 10", i, $signed(dut_q[i][15:0])); end
      end
      tests++; if (dut_q.size() != exp_q.size()) begin fails++; $display("FAIL plus10_model_count: got %0d want %0d", dut_q.size(), exp_q.size()); end
      for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (dut_q[i] !== exp_q[i]) begin fails++; $display("FAIL plus10_model[%0d]: got cyc %0d ph %0d want cyc %0d ph %0d", i, dut_q[i][47:16], $signed(dut_q[i][15:0]), exp_q[i][47:16], $signed(exp_q[i][15:0])); end
      end
   endtask

   task automatic test_minus30();
      do_reset();
      P = 100; OFF = 70;
      run_ticks(650);
      tests++; if (dut_q.size() != 4) begin fails++; $display("FAIL minus30_pulse_count: got %0d want 4", dut_q.size()); end
      tests++; if (phase_err !== -16'sd30) begin fails++; $display("FAIL minus30_phase: got %0d want -30", phase_err); end
      tests++; if (beat_period !== 16'd100) begin fails++; $display("FAIL minus30_period: got %0d want 100", beat_period); end
      for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (dut_q[i] !== exp_q[i]) begin fails++; $display("FAIL minus30_model[%0d]: got cyc %0d ph %0d want cyc %0d ph %0d", i, dut_q[i][47:16], $signed(dut_q[i][15:0]), exp_q[i][47:16], $signed(exp_q[i][15:0])); end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      P = 100; OFF = 10;
      run_ticks(300);
      clear_obs();
      glitch = 1'b1;
      run_ticks(200);
      glitch = 1'b0;
      tests++; if (beat_period !== 16'd100) begin fails++; $display("FAIL glitch_period: got %0d want 100", beat_period); end
      tests++; if (period_valid !== 1'b1) begin fails++; $display("FAIL glitch_period_valid: got %b want 1", period_valid); end
      tests++; if (dut_q.size() != 2) begin fails++; $display("FAIL glitch_pulse_count: got %0d want 2", dut_q.size()); end
      tests++; if (phase_err !== 16'sd10) begin fails++; $display("FAIL glitch_phase: got %0d want 10", phase_err); end
   endtask

   task automatic test_miss();
      do_reset();
      P = 100; OFF = 10;
      run_ticks(260);
      tests++; if (miss !== 1'b0) begin fails++; $display("FAIL miss_before_hold: got %b want 0", miss); end
      fb_hold = 1'b1;
      run_ticks(200);
      fb_hold = 1'b0;
      tests++; if (miss !== 1'b1) begin fails++; $display("FAIL miss_after_hold: got %b want 1", miss); end
      clear_obs();
      run_ticks(100);
      tests++; if (dut_q.size() != 1) begin fails++; $display("FAIL miss_resume_count: got %0d want 1", dut_q.size()); end
      tests++; if (phase_err !== 16'sd10) begin fails++; $display("FAIL miss_resume_phase: got %0d want 10", phase_err); end
      tests++; if (miss !== 1'b1) begin fails++; $display("FAIL miss_sticky: got %b want 1", miss); end
   endtask

   task automatic test_ena_freeze();
      do_reset();
      P = 100; OFF = 70;
      run_ticks(305);
      clear_obs();
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b1);
      tests++; if (dut.tick_cnt !== 16'd305) begin fails++; $display("FAIL ena_tick_frozen: got %0d want 305", dut.tick_cnt); end
      tests++; if (dut_q.size() != 0) begin fails++; $display("FAIL ena_no_pulse: got %0d pulses want 0", dut_q.size()); end
      run_ticks(100);
      tests++; if (dut_q.size() != 1) begin fails++; $display("FAIL ena_release_count: got %0d want 1", dut_q.size()); end
      tests++; if (phase_err !== -16'sd30) begin fails++; $display("FAIL ena_release_phase: got %0d want -30", phase_err); end
      for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (dut_q[i] !== exp_q[i]) begin fails++; $display("FAIL ena_model[%0d]: got cyc %0d ph %0d want cyc %0d ph %0d", i, dut_q[i][47:16], $signed(dut_q[i][15:0]), exp_q[i][47:16], $signed(exp_q[i][15:0])); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      P = 100; OFF = 70;
      run_ticks(360);
      step(1'b0, 1'b1, 1'b1);
      tests++; if (phase_valid !== 1'b0) begin fails++; $display("FAIL rstmid_phase_valid: got %b want 0", phase_valid); end
      tests++; if (phase_err !== 16'sd0) begin fails++; $display("FAIL rstmid_phase_err: got %0d want 0", phase_err); end
      tests++; if (beat_period !== 16'd0) begin fails++; $display("FAIL rstmid_beat_period: got %0d want 0", beat_period); end
      tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL rstmid_period_valid: got %b want 0", period_valid); end
      tests++; if (miss !== 1'b0) begin fails++; $display("FAIL rstmid_miss: got %b want 0", miss); end
      clear_obs();
      run_ticks(210);
      tests++; if (dut_q.size() != 0) begin fails++; $display("FAIL rstmid_early_pulse: got %0d pulses want 0", dut_q.size()); end
      run_ticks(150);
      tests++; if (dut_q.size() != 1) begin fails++; $display("FAIL rstmid_first_pulse: got %0d pulses want 1", dut_q.size()); end
      tests++; if (phase_err !== -16'sd30) begin fails++; $display("FAIL rstmid_phase: got %0d want -30", phase_err); end
      tests++; if (dut_q.size() != exp_q.size()) begin fails++; $display("FAIL rstmid_model_count: got %0d want %0d", dut_q.size(), exp_q.size()); end
   endtask

   task automatic test_random();
      int n;
      bit e, h;
      for (int round = 0; round < 8; round++) begin
         do_reset();
         P   = $urandom_range(10, 120);
         OFF = $urandom_range(0, P - 1);
         n   = P * 8 + 50;
         for (int i = 0; i < n; i++) begin
            e = ($urandom_range(0, 49) != 0);
            h = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) fb_hold = !fb_hold;
            step(1'b1, e, h);
         end
         fb_hold = 1'b0;
         tests++; if (dut_q.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_count: P=%0d off=%0d got %0d want %0d", round, P, OFF, dut_q.size(), exp_q.size()); end
         for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (dut_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_pulse[%0d]: got cyc %0d ph %0d want cyc %0d ph %0d", round, i, dut_q[i][47:16], $signed(dut_q[i][15:0]), exp_q[i][47:16], $signed(exp_q[i][15:0])); end
         end
         tests++; if (beat_period !== 16'(m_period)) begin fails++; $display("FAIL rand%0d_period: got %0d want %0d", round, beat_period, m_period); end
         tests++; if (period_valid !== m_pv) begin fails++; $display("FAIL rand%0d_period_valid: got %b want %b", round, period_valid, m_pv); end
         tests++; if (miss !== m_miss) begin fails++; $display("FAIL rand%0d_miss: got %b want %b", round, miss, m_miss); end
      end
   endtask

   initial begin
      test_reset();
      test_lock_plus10();
      test_minus30();
      test_glitch();
      test_miss();
      test_ena_freeze();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard stop in case stimulus ever stalls.
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
